// File: rtl/rom_socket_mux.sv
// Purpose    : shares one synchronous read memory between CHANNELS ROM sockets,
//              with a per-socket one-entry cache (tag/data/valid).
// Latency    : a stable address seen at edge E0 is granted in the following cycle
//              and sock_valid rises after E2. Worst case under contention is 2+(CHANNELS-1) edges.
// Backpressure: none. Sockets wait on sock_valid, and the memory accepts one read per cycle.
// Ports      : clk_core, reset_n (async, active-low)
//              sock_ce_n/sock_oe_n/sock_a : per-socket strobes and address, channel k in slice k
//              sock_d/sock_valid          : per-socket read data (all ones when not driven) and hit flag
//              mem_en/mem_addr/mem_dout   : shared memory port; read data returns one cycle after mem_en
// Option     : define ROM_SOCKET_MUX_TAG_RETAIN_EN to keep cached data across ce_n deassertion.
module rom_socket_mux #(
    parameter  int CHANNELS   = 2,
    parameter  int ADDR_WIDTH = 13,
    parameter  int DATA_WIDTH = 8,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                           clk_core,
    input  logic                           reset_n,
    input  logic [CHANNELS-1:0]            sock_ce_n,
    input  logic [CHANNELS-1:0]            sock_oe_n,
    input  logic [CHANNELS*ADDR_WIDTH-1:0] sock_a,
    output logic [CHANNELS*DATA_WIDTH-1:0] sock_d,
    output logic [CHANNELS-1:0]            sock_valid,
    output logic                           mem_en,
    output logic [ADDR_WIDTH+CH_W-1:0]     mem_addr,
    input  logic [DATA_WIDTH-1:0]          mem_dout
);

    // Input stage. All decisions are made on these registered copies.
    logic [CHANNELS-1:0]   r_ce_n;
    logic [CHANNELS-1:0]   r_oe_n;
    logic [ADDR_WIDTH-1:0] r_a    [CHANNELS];

    // Per-channel cache entry.
    logic [ADDR_WIDTH-1:0] r_tag  [CHANNELS];
    logic [DATA_WIDTH-1:0] r_data [CHANNELS];
    logic [CHANNELS-1:0]   r_valid;

    // Single in-flight slot. The memory answers one cycle after a grant,
    // so a new grant every cycle simply replaces it.
    logic                  r_inf_vld;
    logic [CH_W-1:0]       r_inf_ch;
    logic [ADDR_WIDTH-1:0] r_inf_addr;

    logic [CH_W-1:0]            r_rr_ptr;
    logic [ADDR_WIDTH+CH_W-1:0] r_mem_addr;

    logic [CHANNELS-1:0]   w_pend;
    logic [CHANNELS-1:0]   w_commit;
    logic                  w_gnt_vld;
    logic [CH_W-1:0]       w_gnt_ch;
    logic [ADDR_WIDTH-1:0] w_gnt_addr;

    always_comb begin
        w_pend = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            w_pend[k] = !r_ce_n[k] && (!r_valid[k] || (r_tag[k] != r_a[k]))
                        && !(r_inf_vld && (r_inf_ch == CH_W'(k)));
        end
    end

    // Round-robin search from r_rr_ptr upward, done as two passes:
    // first channels at or above the pointer, then the wrapped ones below it.
    always_comb begin
        w_gnt_vld  = 1'b0;
        w_gnt_ch   = '0;
        w_gnt_addr = '0;
        for (int j = 0; j < CHANNELS; j++) begin
            if (!w_gnt_vld && w_pend[j] && (CH_W'(j) >= r_rr_ptr)) begin
                w_gnt_vld  = 1'b1;
                w_gnt_ch   = CH_W'(j);
                w_gnt_addr = r_a[j];
            end
        end
        for (int j = 0; j < CHANNELS; j++) begin
            if (!w_gnt_vld && w_pend[j] && (CH_W'(j) < r_rr_ptr)) begin
                w_gnt_vld  = 1'b1;
                w_gnt_ch   = CH_W'(j);
                w_gnt_addr = r_a[j];
            end
        end
    end

    // A returning read is kept only if the socket still presents the address
    // that was fetched. Otherwise it is dropped and the channel pends again.
    always_comb begin
        w_commit = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            w_commit[k] = r_inf_vld && (r_inf_ch == CH_W'(k)) && (r_a[k] == r_inf_addr);
        end
`ifndef ROM_SOCKET_MUX_TAG_RETAIN_EN
        // A deselected socket must refetch on reselect, so never fill it while deselected.
        w_commit = w_commit & ~r_ce_n;
`endif
    end

    assign mem_en   = w_gnt_vld;
    assign mem_addr = w_gnt_vld ? {w_gnt_ch, w_gnt_addr} : r_mem_addr;

    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            r_ce_n     <= '1;
            r_oe_n     <= '1;
            r_valid    <= '0;
            r_inf_vld  <= 1'b0;
            r_inf_ch   <= '0;
            r_inf_addr <= '0;
            r_rr_ptr   <= '0;
            r_mem_addr <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                r_a[k]    <= '0;
                r_tag[k]  <= '0;
                r_data[k] <= '0;
            end
        end else begin
            r_ce_n    <= sock_ce_n;
            r_oe_n    <= sock_oe_n;
            r_inf_vld <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_inf_ch   <= w_gnt_ch;
                r_inf_addr <= w_gnt_addr;
                r_mem_addr <= {w_gnt_ch, w_gnt_addr};
                r_rr_ptr   <= (w_gnt_ch == CH_W'(CHANNELS - 1)) ? '0 : w_gnt_ch + CH_W'(1);
            end
            for (int k = 0; k < CHANNELS; k++) begin
                r_a[k] <= sock_a[k*ADDR_WIDTH +: ADDR_WIDTH];
                if (w_commit[k]) begin
                    r_data[k]  <= mem_dout;
                    r_tag[k]   <= r_inf_addr;
                    r_valid[k] <= 1'b1;
                end
                // An address change invalidates the entry on the same edge that
                // registers the new address, and overrides a commit on that edge.
                if (sock_a[k*ADDR_WIDTH +: ADDR_WIDTH] != r_a[k]) begin
                    r_valid[k] <= 1'b0;
                end
`ifndef ROM_SOCKET_MUX_TAG_RETAIN_EN
                if (sock_ce_n[k]) begin
                    r_valid[k] <= 1'b0;
                end
`endif
            end
        end
    end

    always_comb begin
        sock_d = '1;
        for (int k = 0; k < CHANNELS; k++) begin
            if (!r_ce_n[k] && !r_oe_n[k] && r_valid[k]) begin
                sock_d[k*DATA_WIDTH +: DATA_WIDTH] = r_data[k];
            end
        end
    end

    assign sock_valid = r_valid & ~r_ce_n;

endmodule

// File: tb/tb_rom_socket_mux.sv
// Bench for rom_socket_mux (CHANNELS=2). A queue holds the expected memory reads,
// and a forked monitor pops and compares them whenever mem_en is seen.
module tb_rom_socket_mux;
    localparam int C  = 2;
    localparam int A  = 13;
    localparam int D  = 8;
    localparam int CW = 1;
    localparam int MW = A + CW;

    logic           clk_core = 1'b0;
    logic           reset_n;
    logic [C-1:0]   sock_ce_n;
    logic [C-1:0]   sock_oe_n;
    logic [C*A-1:0] sock_a;
    logic [C*D-1:0] sock_d;
    logic [C-1:0]   sock_valid;
    logic           mem_en;
    logic [MW-1:0]  mem_addr;
    logic [D-1:0]   mem_dout;

    always #5 clk_core = ~clk_core;

    rom_socket_mux #(.CHANNELS(C), .ADDR_WIDTH(A), .DATA_WIDTH(D)) dut (
        .clk_core   (clk_core),
        .reset_n    (reset_n),
        .sock_ce_n  (sock_ce_n),
        .sock_oe_n  (sock_oe_n),
        .sock_a     (sock_a),
        .sock_d     (sock_d),
        .sock_valid (sock_valid),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_dout   (mem_dout)
    );

    // Memory image contents, chosen as an arbitrary function of the full address.
    function automatic logic [7:0] rom(input logic [MW-1:0] a);
        if (a == MW'(14'h1234)) return 8'hA5;
        return 8'(a) ^ 8'(a >> 6) ^ 8'h3C;
    endfunction

    // Synchronous memory. Between reads it returns noise, so data captured
    // on the wrong cycle does not match.
    always @(posedge clk_core) mem_dout <= mem_en ? rom(mem_addr) : 8'($urandom);

    int            checks = 0;
    int            errors = 0;
    logic [MW-1:0] exp_q[$];

    // Reference model: which socket holds valid data for which address,
    // and where the round-robin resumes.
    logic          m_valid [C];
    logic [A-1:0]  m_addr  [C];
    int            m_rr;
    logic [C-1:0]  nxt_ce;
    logic [C-1:0]  nxt_oe;
    logic [A-1:0]  nxt_a   [C];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < C; k++) sock_a[k*A +: A] = nxt_a[k];
        sock_ce_n = nxt_ce;
        sock_oe_n = nxt_oe;
    endtask

    // Apply nxt_* to the sockets and predict the memory reads they cause, in order.
    task automatic apply();
        logic fetch [C];
        logic v;
        int   last;
        last = -1;
        for (int k = 0; k < C; k++) begin
            v = m_valid[k] && (nxt_a[k] == m_addr[k]);
`ifndef ROM_SOCKET_MUX_TAG_RETAIN_EN
            if (nxt_ce[k]) v = 1'b0;
`endif
            fetch[k]   = !nxt_ce[k] && !v;
            m_valid[k] = fetch[k] || v;
            m_addr[k]  = nxt_a[k];
        end
        for (int i = 0; i < C; i++) begin
            int k;
            k = (m_rr + i) % C;
            if (fetch[k]) begin
                exp_q.push_back({CW'(k), nxt_a[k]});
                last = k;
            end
        end
        if (last >= 0) m_rr = (last + 1) % C;
        drive();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        nxt_ce  = '1;
        nxt_oe  = '1;
        for (int k = 0; k < C; k++) begin
            nxt_a[k]   = '0;
            m_valid[k] = 1'b0;
            m_addr[k]  = '0;
        end
        m_rr = 0;
        drive();
        repeat (2) @(negedge clk_core);
        reset_n = 1'b1;
        @(negedge clk_core);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk_core);
                if (mem_en === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_read: got mem_addr 0x%0h expected no read", mem_addr);
                    end else begin
                        logic [MW-1:0] e;
                        e = exp_q.pop_front();
                        if (mem_addr !== e) begin
                            errors++;
                            $display("FAIL read_addr: got 0x%0h expected 0x%0h", mem_addr, e);
                        end
                    end
                end
            end
        join_none

        // Reset state.
        reset_n = 1'b0;
        nxt_ce = '1; nxt_oe = '1;
        for (int k = 0; k < C; k++) begin nxt_a[k] = '0; m_valid[k] = 1'b0; m_addr[k] = '0; end
        m_rr = 0;
        drive();
        #12;
        chk("reset_mem_en", 32'(mem_en), 0);
        chk("reset_mem_addr", 32'(mem_addr), 0);
        chk("reset_sock_valid", 32'(sock_valid), 0);
        chk("reset_sock_d", 32'(sock_d), 32'hFFFF);
        do_reset();

        // Single uncontended fetch.
        nxt_ce = 2'b10; nxt_oe = 2'b10; nxt_a[0] = 13'h1234;
        apply();
        @(negedge clk_core);
        chk("single_mem_en", 32'(mem_en), 1);
        chk("single_valid_e0", 32'(sock_valid[0]), 0);
        @(negedge clk_core);
        chk("single_valid_e1", 32'(sock_valid[0]), 0);
        @(negedge clk_core);
        chk("single_valid_e2", 32'(sock_valid[0]), 1);
        chk("single_data", 32'(sock_d[7:0]), 32'hA5);

        // Output enable gates the data only.
        nxt_oe = 2'b11; apply();
        repeat (2) @(negedge clk_core);
        chk("oe_high_data", 32'(sock_d[7:0]), 32'hFF);
        chk("oe_high_valid", 32'(sock_valid[0]), 1);
        nxt_oe = 2'b10; apply();
        repeat (2) @(negedge clk_core);
        chk("oe_low_data", 32'(sock_d[7:0]), 32'hA5);

        // Deselect then reselect at the same address.
        nxt_ce = 2'b11; apply();
        repeat (2) @(negedge clk_core);
        chk("deselect_valid", 32'(sock_valid[0]), 0);
        nxt_ce = 2'b10; apply();
        @(negedge clk_core);
`ifdef ROM_SOCKET_MUX_TAG_RETAIN_EN
        chk("reselect_e0", 32'(sock_valid[0]), 1);
`else
        chk("reselect_e0", 32'(sock_valid[0]), 0);
`endif
        repeat (2) @(negedge clk_core);
        chk("reselect_e2", 32'(sock_valid[0]), 1);
        chk("reselect_data", 32'(sock_d[7:0]), 32'hA5);
        chk("reselect_drained", 32'(exp_q.size()), 0);

        // Both channels request on the same edge.
        do_reset();
        nxt_ce = 2'b00; nxt_oe = 2'b00; nxt_a[0] = 13'h0010; nxt_a[1] = 13'h0020;
        apply();
        @(negedge clk_core);
        chk("contend_first", 32'(mem_addr), 32'h0010);
        @(negedge clk_core);
        chk("contend_second", 32'(mem_addr), 32'h2020);
        repeat (2) @(negedge clk_core);
        chk("contend_valid", 32'(sock_valid), 32'h3);
        chk("contend_data", 32'(sock_d), {16'h0, rom(14'h2020), rom(14'h0010)});
        nxt_a[0] = 13'h0011; nxt_a[1] = 13'h0021;   // the pointer is back at ch0
        apply();
        repeat (5) @(negedge clk_core);
        chk("contend2_drained", 32'(exp_q.size()), 0);

        // Address changes while its read is in flight.
        do_reset();
        nxt_ce = 2'b10; nxt_oe = 2'b10; nxt_a[0] = 13'h0100;
        apply();
        repeat (2) @(negedge clk_core);
        nxt_a[0] = 13'h0101;
        apply();
        @(negedge clk_core);
        chk("stale_not_valid", 32'(sock_valid[0]), 0);
        repeat (4) @(negedge clk_core);
        chk("refetch_valid", 32'(sock_valid[0]), 1);
        chk("refetch_data", 32'(sock_d[7:0]), 32'(rom(14'h0101)));
        chk("refetch_drained", 32'(exp_q.size()), 0);

        // Reset while a read is in flight.
        do_reset();
        nxt_ce = 2'b10; nxt_oe = 2'b10; nxt_a[0] = 13'h0000;
        apply();
        @(negedge clk_core);
        @(posedge clk_core);
        #2 reset_n = 1'b0;
        #1;
        chk("flight_rst_mem_en", 32'(mem_en), 0);
        chk("flight_rst_mem_addr", 32'(mem_addr), 0);
        chk("flight_rst_valid", 32'(sock_valid), 0);
        chk("flight_rst_data", 32'(sock_d), 32'hFFFF);
        @(negedge clk_core);
        reset_n = 1'b1;
        for (int k = 0; k < C; k++) m_valid[k] = 1'b0;
        m_rr = 0;
        apply();
        @(negedge clk_core);
        chk("flight_rst_ignored", 32'(sock_valid[0]), 0);
        repeat (4) @(negedge clk_core);
        chk("flight_rst_refetch", 32'(sock_valid[0]), 1);
        chk("flight_rst_data2", 32'(sock_d[7:0]), 32'(rom(14'h0000)));

        // Randomised phases: inputs change together, then settle.
        for (int ph = 0; ph < 80; ph++) begin
            for (int k = 0; k < C; k++) begin
                nxt_ce[k] = ($urandom_range(0, 9) < 3);
                nxt_oe[k] = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 1) == 1) nxt_a[k] = A'($urandom_range(0, 15) << $urandom_range(0, 9));
            end
            apply();
            repeat (C + 5) @(negedge clk_core);
            chk($sformatf("phase%0d_drained", ph), 32'(exp_q.size()), 0);
            for (int k = 0; k < C; k++) begin
                logic [7:0] ed;
                ed = (!nxt_ce[k] && !nxt_oe[k]) ? rom({CW'(k), nxt_a[k]}) : 8'hFF;
                chk($sformatf("phase%0d_valid%0d", ph, k), 32'(sock_valid[k]), 32'(!nxt_ce[k]));
                chk($sformatf("phase%0d_data%0d", ph, k), 32'(sock_d[k*D +: D]), 32'(ed));
            end
        end

        repeat (4) @(negedge clk_core);
        chk("final_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
